bin_to_bcd_seq: RTL



---
 rtl/bin_to_bcd_seq.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3), one input bit per clock.
// Registered result with overflow saturation, leading-zero blank mask and sign.
module bin_to_bcd_seq #(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4,
  parameter int SIGNED = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [BIN_W-1:0]    in,
  output logic                ready,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] bcd,
  output logic [DIGITS-1:0]   blank,
  output logic                neg,
  output logic                ovf
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BIN_W - 1);
  localparam logic [BCD_W-1:0] NINES = {DIGITS{4'h9}};
  localparam logic [DIGITS-1:0] BLANK_RST = ~(DIGITS'(1));

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [BIN_W-1:0] bin_q;
  logic [BCD_W-1:0] work;
  logic             ovf_w;
  logic             sign_q;
  logic [CNT_W-1:0] cnt;

  logic             accept;
  logic             step;
  logic             finish;

  logic [BIN_W-1:0] mag;
  logic             in_neg;
  logic [BCD_W-1:0] adj;
  logic [BCD_W-1:0] shifted;
  logic             carry;
  logic [BCD_W-1:0] res_bcd;
  logic [DIGITS-1:0] res_blank;

  assign ready = (state == IDLE);
  assign busy  = ~ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    step     = 1'b0;
    finish   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          accept   = 1'b1;
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        step = 1'b1;
        if (cnt == LAST) state_nx = DONE;
      end
      DONE: begin
        finish   = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Two's-complement inputs are converted as magnitude; the most
  // negative value still fits because the magnitude is taken unsigned.
  always_comb begin
    mag    = in;
    in_neg = 1'b0;
    if (SIGNED != 0 && in[BIN_W-1]) begin
      mag    = ~in + BIN_W'(1);
      in_neg = 1'b1;
    end
  end

  always_comb begin
    adj = work;
    for (int i = 0; i < DIGITS; i++) begin
      if (work[4*i +: 4] > 4'd4)
        adj[4*i +: 4] = work[4*i +: 4] + 4'd3;
    end
  end

  assign shifted = {adj[BCD_W-2:0], bin_q[BIN_W-1]};
  assign carry   = adj[BCD_W-1];

  assign res_bcd = ovf_w ? NINES : work;

  always_comb begin
    logic zero_above;
    zero_above = 1'b1;
    res_blank  = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above   = zero_above & (res_bcd[4*i +: 4] == 4'd0);
      res_blank[i] = zero_above;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bin_q  <= '0;
      work   <= '0;
      ovf_w  <= 1'b0;
      sign_q <= 1'b0;
      cnt    <= '0;
      done   <= 1'b0;
      bcd    <= '0;
      blank  <= BLANK_RST;
      neg    <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        bin_q  <= mag;
        work   <= '0;
        ovf_w  <= 1'b0;
        sign_q <= in_neg;
        cnt    <= '0;
      end
      if (step) begin
        bin_q <= {bin_q[BIN_W-2:0], 1'b0};
        work  <= shifted;
        ovf_w <= ovf_w | carry;
        cnt   <= cnt + CNT_W'(1);
      end
      if (finish) begin
        done  <= 1'b1;
        bcd   <= res_bcd;
        blank <= res_blank;
        neg   <= sign_q;
        ovf   <= ovf_w;
      end
    end
  end

endmodule
